// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared FSM encoding, default parameters and the FIFO headroom helper
// for the multi-requester FIFO write arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 9;
    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_BURST_LEN  = 4;

    // Two slots of headroom: one for the write already sitting in the output
    // register, one for the beat being accepted this cycle.
    function automatic int unsigned space_limit(input int unsigned addr_width);
        return (32'd1 << addr_width) - 32'd2;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester handshake plus FIFO flag/write bundle; slave side is the arbiter,
// master side is whoever owns the requesters and the FIFO.
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_REQ    = DEF_NUM_REQ
);
    localparam int ID_WIDTH = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            gnt;
    logic                          Full;
    logic [ADDR_WIDTH-1:0]         Fcounter;
    logic                          Write_enable;
    logic [DATA_WIDTH-1:0]         Write_data;
    logic [ID_WIDTH-1:0]           Write_id;

    modport master (
        output req, req_data, Full, Fcounter,
        input  gnt, Write_enable, Write_data, Write_id
    );

    modport slave (
        input  req, req_data, Full, Fcounter,
        output gnt, Write_enable, Write_data, Write_id
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin search: first asserted req at or above rr_ptr, wrapping.
// Zero latency; no backpressure of its own.
module rr_picker #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic                       pick_vld,
    output logic [$clog2(NUM_REQ)-1:0] pick_idx
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [IDW-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest hit wins last.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = rr_ptr;
        idx      = rr_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = rr_ptr + IDW'(k);
            if (req[idx]) begin
                pick_vld = 1'b1;
                pick_idx = idx;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter funnelling NUM_REQ valid/ready requesters into one FIFO write port.
// Accepted beat appears on Write_* one cycle later; gnt drops whenever FIFO headroom runs out.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int BURST_LEN  = DEF_BURST_LEN
) (
    input  logic             Clock,
    input  logic             Fifo_rst,
    fifo_wr_arbiter_if.slave bus
);
    localparam int                    ID_WIDTH  = $clog2(NUM_REQ);
    localparam logic [ADDR_WIDTH-1:0] SPACE_LIM = ADDR_WIDTH'(space_limit(ADDR_WIDTH));
    localparam logic [3:0]            LAST_BEAT = 4'(BURST_LEN);

    arb_state_t            state, state_nxt;
    logic [ID_WIDTH-1:0]   owner, owner_nxt;
    logic [ID_WIDTH-1:0]   rr_ptr, rr_nxt;
    logic [ID_WIDTH-1:0]   pick_idx;
    logic [3:0]            beat_cnt, beat_nxt;
    logic                  pick_vld;
    logic                  space;
    logic                  own_req;
    logic                  xfer;
    logic [NUM_REQ-1:0]    gnt_c;
    logic [DATA_WIDTH-1:0] own_dat;

    logic                  wr_en_q;
    logic [DATA_WIDTH-1:0] wr_dat_q;
    logic [ID_WIDTH-1:0]   wr_id_q;

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req      (bus.req),
        .rr_ptr   (rr_ptr),
        .pick_vld (pick_vld),
        .pick_idx (pick_idx)
    );

    assign space   = !bus.Full && (bus.Fcounter < SPACE_LIM);
    assign own_req = bus.req[owner];
    assign own_dat = bus.req_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        rr_nxt    = rr_ptr;
        beat_nxt  = beat_cnt;
        gnt_c     = '0;
        xfer      = 1'b0;
        case (state)
            IDLE: begin
                if (pick_vld && space) begin
                    owner_nxt = pick_idx;
                    beat_nxt  = 4'd0;
                    state_nxt = BURST;
                end
            end
            BURST: begin
                xfer         = own_req && space;
                gnt_c[owner] = xfer;
                if (xfer) begin
                    beat_nxt = beat_cnt + 4'd1;
                end
                // A stall with req still high keeps the burst; only a drop or the last beat ends it.
                if (!own_req || (xfer && (beat_cnt + 4'd1 == LAST_BEAT))) begin
                    state_nxt = IDLE;
                    rr_nxt    = owner + ID_WIDTH'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Fifo_rst) begin
        if (Fifo_rst) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            rr_ptr   <= rr_nxt;
            beat_cnt <= beat_nxt;
        end
    end

    // Reset clears wr_en_q, so a beat accepted just before reset is never written.
    always_ff @(posedge Clock or posedge Fifo_rst) begin
        if (Fifo_rst) begin
            wr_en_q  <= 1'b0;
            wr_dat_q <= '0;
            wr_id_q  <= '0;
        end else begin
            wr_en_q <= xfer;
            if (xfer) begin
                wr_dat_q <= own_dat;
                wr_id_q  <= owner;
            end
        end
    end

    assign bus.gnt          = gnt_c;
    assign bus.Write_enable = wr_en_q;
    assign bus.Write_data   = wr_dat_q;
    assign bus.Write_id     = wr_id_q;

endmodule
